// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: opcode and FSM
// state enums, instruction field positions and flag bit indices.
package seq_pkg;

    localparam int OP_HI  = 31;
    localparam int OP_LO  = 28;
    localparam int RS_HI  = 27;
    localparam int RS_LO  = 24;
    localparam int RT_HI  = 23;
    localparam int RT_LO  = 20;
    localparam int RD_HI  = 19;
    localparam int RD_LO  = 16;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    // Bit positions of the flags output, packed as {Z, N, C, V}
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLL  = 4'd5,
        OP_SRL  = 4'd6,
        OP_SRA  = 4'd7,
        OP_ADDI = 4'd8,
        OP_SLT  = 4'd9,
        OP_NOT  = 4'd10,
        OP_LUI  = 4'd11,
        OP_NOP  = 4'd15
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_EXEC = 2'd2,
        S_WB   = 2'd3
    } state_e;

endpackage

// File: rtl/seq_alu.sv
// Combinational ALU for the sequencer. Add, sub and addi share one 33-bit
// adder so carry and overflow come from a single sum.
module seq_alu
    import seq_pkg::*;
(
    input  opcode_e     op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [15:0] imm,
    output logic [31:0] result,
    output logic        c,
    output logic        v,
    output logic        illegal
);

    logic [31:0] addend;
    logic [32:0] sum;

    // SUB folds into the adder as a + ~b + 1, so C=1 means no borrow
    always_comb begin
        addend = b;
        if (op == OP_SUB) begin
            addend = ~b;
        end else if (op == OP_ADDI) begin
            addend = {{16{imm[15]}}, imm};
        end
        sum = {1'b0, a} + {1'b0, addend} + {32'd0, (op == OP_SUB)};
    end

    always_comb begin
        result  = 32'd0;
        c       = 1'b0;
        v       = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_ADDI: begin
                result = sum[31:0];
                c      = sum[32];
                v      = (a[31] == addend[31]) && (sum[31] != a[31]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            OP_NOT:  result = ~a;
            OP_LUI:  result = {imm, 16'd0};
            OP_NOP:  result = 32'd0;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Four-state execute sequencer driving the 16x32 register bank.
// Optional flags register enabled by defining INSTR_SEQUENCER_FLAGS_EN.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int RADDR = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_valid,
    input  logic [31:0]      instr,
    output logic             instr_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             rd1,
    output logic             rd2,
    output logic [RADDR-1:0] src1,
    output logic [RADDR-1:0] src2,
    output logic [RADDR-1:0] dest,
    output logic             wr,
    output logic [WIDTH-1:0] z,
    output logic             busy,
    output logic             err,
    output logic [3:0]       flags,
    output state_e           dbg_state
);

    // Handshake: an instruction transfers on a posedge where instr_valid and
    // instr_ready are both high; instr_ready is high only in IDLE.
    state_e           state_q, state_d;
    logic [31:0]      ir_q, ir_d;
    logic [WIDTH-1:0] z_q, z_d;
    logic             err_q, err_d;

    opcode_e          ir_op;
    logic [31:0]      alu_result;
    logic             alu_c, alu_v, alu_illegal;

    assign ir_op = opcode_e'(ir_q[OP_HI:OP_LO]);

    seq_alu u_alu (
        .op      (ir_op),
        .a       (a),
        .b       (b),
        .imm     (ir_q[IMM_HI:IMM_LO]),
        .result  (alu_result),
        .c       (alu_c),
        .v       (alu_v),
        .illegal (alu_illegal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q    <= 32'd0;
            z_q     <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            z_q     <= z_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        z_d     = z_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    ir_d    = instr;
                    err_d   = 1'b0;
                    state_d = S_READ;
                end
            end
            S_READ: state_d = S_EXEC;
            S_EXEC: begin
                z_d = alu_result;
                if (alu_illegal) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_WB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Controls decode straight from the reset-cleared state so rst drops them at once
    assign instr_ready = (state_q == S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign rd1         = (state_q == S_READ);
    assign rd2         = (state_q == S_READ);
    assign src1        = ir_q[RS_HI:RS_LO];
    assign src2        = ir_q[RT_HI:RT_LO];
    assign dest        = ir_q[RD_HI:RD_LO];
    assign wr          = (state_q == S_WB) && (dest != '0) && (ir_op != OP_NOP);
    assign z           = z_q;
    assign err         = err_q;
    assign dbg_state   = state_q;

`ifdef INSTR_SEQUENCER_FLAGS_EN
    logic [3:0] flags_q, flags_d;
    logic       res_zero;

    assign res_zero = (alu_result == 32'd0);

    always_comb begin
        flags_d = flags_q;
        if (state_q == S_EXEC && !alu_illegal) begin
            case (ir_op)
                OP_ADD, OP_SUB, OP_ADDI: begin
                    flags_d[FLAG_Z] = res_zero;
                    flags_d[FLAG_N] = alu_result[31];
                    flags_d[FLAG_C] = alu_c;
                    flags_d[FLAG_V] = alu_v;
                end
                OP_AND, OP_OR, OP_XOR, OP_NOT: begin
                    flags_d[FLAG_Z] = res_zero;
                    flags_d[FLAG_N] = alu_result[31];
                    flags_d[FLAG_C] = 1'b0;
                    flags_d[FLAG_V] = 1'b0;
                end
                default: flags_d = flags_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 4'd0;
        end else begin
            flags_q <= flags_d;
        end
    end

    assign flags = flags_q;
`else
    logic unused_alu_cv;
    assign unused_alu_cv = alu_c ^ alu_v;
    assign flags         = 4'd0;
`endif

endmodule
